p2s_sched: RTL and testbench
============================

# p2s_sched

Round-robin scheduler that shares the single 64-bit parallel-to-serial shift channel between two display requesters: requester 0 is the seven-segment path and requester 1 is the LED path. It captures the granted requester's word and issues a clean start pulse to the shifter. It then tracks the shifter's EN (idle/done) flag through the whole transfer and returns a one-cycle acknowledge. It sits between the display data sources and the serial shifter that drives the board's shift-register chain.

## Interface
- DATA_BITS, 64, width of each parallel word.
- START_WAIT, 4, cycles allowed for p2s_en to drop after a start pulse before a start timeout is declared.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- seg_req  in  1  requester 0 request; level, held until seg_ack.
- seg_data  in  DATA_BITS  requester 0 word; sampled in the grant cycle.
- seg_ack  out  1  one-cycle pulse when requester 0's transfer ends.
- led_req  in  1  requester 1 request; level, held until led_ack.
- led_data  in  DATA_BITS  requester 1 word; sampled in the grant cycle.
- led_ack  out  1  one-cycle pulse when requester 1's transfer ends.
- p2s_start  out  1  start to the shifter; the shifter acts on its rising edge.
- p2s_pdata  out  DATA_BITS  registered word; held constant from grant until ack.
- p2s_en  in  1  shifter flag: 1 means idle/done, 0 means shifting.
- busy  out  1  high in every state except IDLE.
- grant_id  out  1  id of the current or last granted requester.
- err  out  1  one-cycle pulse on a start timeout.

## Operation
- States:
  - IDLE: grant only when p2s_en=1 and (seg_req | led_req) is true.
    - Latch the winner's data into p2s_pdata, set grant_id, go to START.
  - START: p2s_start=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: count cycles.
    - p2s_en=0 → WAIT_DONE.
    - Count reaches START_WAIT with p2s_en still 1 → pulse err, go to ACK.
  - WAIT_DONE: stay while p2s_en=0; p2s_en=1 → ACK.
  - ACK: pulse seg_ack or led_ack (per grant_id) for one cycle, then go to IDLE.
- Arbitration:
  - Only one request active → grant it.
  - Both active → grant the requester that is not grant_id (round robin).
  - grant_id resets to 1, so requester 0 wins the first tie.
- p2s_start is low in every state except START, so it is low for at least 2 cycles between consecutive pulses. Every pulse is therefore a fresh rising edge.
- A request dropped before grant produces no transfer and no ack. Dropping req after grant does not abort the transfer; the ack is still issued.
- Requester data changes after the grant cycle have no effect on p2s_pdata.
- After an err the requester still receives its ack. err is the only indication of the timeout.
- Reset values: state IDLE, p2s_start 0, p2s_pdata 0, seg_ack 0, led_ack 0, busy 0, err 0, grant_id 1, timeout counter 0.
- Reset mid-transfer returns to IDLE immediately. No ack is issued for the aborted transfer.
  - The shifter itself may still be shifting; the IDLE guard (p2s_en=1) blocks any new grant until it finishes.

## Timing
- Request seen in IDLE at cycle n: START at n+1 (p2s_start high), WAIT_BUSY from n+2.
- With a compliant shifter, p2s_en falls by n+3 and WAIT_DONE follows on the next cycle.
- Ack is asserted in the cycle after p2s_en is first sampled 1 in WAIT_DONE.
- Back-to-back: next grant no earlier than 1 cycle after ACK, so there is a minimum 1-cycle IDLE gap.
- Timeout counter width is clog2(START_WAIT+1). It clears on entry to WAIT_BUSY.
- seg_ack and led_ack are never high in the same cycle. err and an ack never coincide: err fires in WAIT_BUSY, the ack follows in ACK.

## Structure
- Shared package p2s_sched_pkg:
  - state encoding constants S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_ACK (3-bit);
  - requester ids ID_SEG=0, ID_LED=1.
- One sub-module, rr_arb2: 2-way round-robin.
  - Inputs: req[1:0] and last grant.
  - Outputs: gnt_valid and gnt_id.
  - Purely combinational; the last-grant register lives in p2s_sched.
- Bench uses a behavioural shifter model: rising-edge start; EN drops 2 cycles after the start edge and rises 64 cycles later.

## Test plan
- seg_req=1 alone, seg_data=64'h0123_4567_89AB_CDEF → one p2s_start pulse at n+1; p2s_pdata=64'h0123_4567_89AB_CDEF until seg_ack; exactly one seg_ack; led_ack never high.
- seg_req and led_req both held high for 3 transfers → grant order seg, led, seg; each ack lasts 1 cycle; at least 2 low cycles between p2s_start pulses.
- Shifter model never drops EN → err pulses once 4 cycles after WAIT_BUSY entry; seg_ack follows in the next cycle; busy then falls.
- Change led_data from 64'hAAAA… to 64'h5555… one cycle after grant → p2s_pdata stays 64'hAAAA… for the whole transfer.
- Assert rst during WAIT_DONE while EN=0 → next cycle all outputs at reset values and no ack; a pending seg_req is not granted until EN=1, then it proceeds normally.
- led_req pulsed for 1 cycle while a seg transfer is busy → no led transfer and no led_ack after seg completes.

Source files
------------

// File: rtl/p2s_sched_pkg.sv
// Shared types and constants for the p2s channel scheduler.
package p2s_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_ACK       = 3'd4
    } state_t;

    localparam logic ID_SEG = 1'b0;
    localparam logic ID_LED = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant state is held by the caller.
module rr_arb2
    import p2s_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_id,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = ID_SEG;
        // On a tie the requester that did not win last time goes next
        if (req == 2'b11) begin
            gnt_id = ~last_id;
        end else if (req[ID_LED]) begin
            gnt_id = ID_LED;
        end
    end

endmodule

// File: rtl/p2s_sched.sv
// Shares one parallel-to-serial shifter between the seven-segment and LED
// requesters: grants, launches the shift, tracks EN and acknowledges.
module p2s_sched
    import p2s_sched_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 64,
    parameter int unsigned START_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seg_req,
    input  logic [DATA_BITS-1:0] seg_data,
    output logic                 seg_ack,
    input  logic                 led_req,
    input  logic [DATA_BITS-1:0] led_data,
    output logic                 led_ack,
    output logic                 p2s_start,
    output logic [DATA_BITS-1:0] p2s_pdata,
    input  logic                 p2s_en,
    output logic                 busy,
    output logic                 grant_id,
    output logic                 err
);

    localparam int unsigned CNT_W = $clog2(START_WAIT + 1);

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [DATA_BITS-1:0] pdata_n;
    logic                 gid_n;
    logic                 err_n;
    logic                 start_n;
    logic                 busy_n;
    logic                 seg_ack_n;
    logic                 led_ack_n;
    logic                 gnt_valid;
    logic                 gnt_id;

    rr_arb2 u_arb (
        .req       ({led_req, seg_req}),
        .last_id   (grant_id),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Next-state and next-output logic; every output is registered from here
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pdata_n = p2s_pdata;
        gid_n   = grant_id;
        err_n   = 1'b0;

        case (state)
            S_IDLE: begin
                // p2s_en=1 also keeps us off a shifter still busy after a reset
                if (p2s_en && gnt_valid) begin
                    state_n = S_START;
                    gid_n   = gnt_id;
                    pdata_n = (gnt_id == ID_LED) ? led_data : seg_data;
                end
            end
            S_START: begin
                state_n = S_WAIT_BUSY;
                cnt_n   = '0;
            end
            S_WAIT_BUSY: begin
                if (cnt == CNT_W'(START_WAIT)) begin
                    state_n = S_ACK;
                end else if (!p2s_en) begin
                    state_n = S_WAIT_DONE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    // err shows in the last WAIT_BUSY cycle, ack follows in ACK
                    if (cnt == CNT_W'(START_WAIT - 1)) begin
                        err_n = 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (p2s_en) begin
                    state_n = S_ACK;
                end
            end
            S_ACK: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        start_n   = (state_n == S_START);
        busy_n    = (state_n != S_IDLE);
        seg_ack_n = (state_n == S_ACK) && (gid_n == ID_SEG);
        led_ack_n = (state_n == S_ACK) && (gid_n == ID_LED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            p2s_pdata <= '0;
            grant_id  <= ID_LED;
            p2s_start <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            seg_ack   <= 1'b0;
            led_ack   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            p2s_pdata <= pdata_n;
            grant_id  <= gid_n;
            p2s_start <= start_n;
            busy      <= busy_n;
            err       <= err_n;
            seg_ack   <= seg_ack_n;
            led_ack   <= led_ack_n;
        end
    end

endmodule

// File: tb/tb_p2s_sched.sv
// Directed and randomized bench for p2s_sched with a behavioural shifter.
module tb_p2s_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seg_req = 1'b0;
    logic [63:0] seg_data = '0;
    logic        seg_ack;
    logic        led_req = 1'b0;
    logic [63:0] led_data = '0;
    logic        led_ack;
    logic        p2s_start;
    logic [63:0] p2s_pdata;
    logic        p2s_en = 1'b1;
    logic        busy;
    logic        grant_id;
    logic        err;

    int nvec = 0;
    int nmis = 0;
    logic last_gnt = 1'b1;

    // Shifter model: EN drops two cycles after a start rising edge, back 64 later
    bit          shf_dead = 1'b0;
    logic        start_q = 1'b0;
    int unsigned pend = 0;
    int unsigned run = 0;

    p2s_sched dut (
        .clk       (clk),
        .rst       (rst),
        .seg_req   (seg_req),
        .seg_data  (seg_data),
        .seg_ack   (seg_ack),
        .led_req   (led_req),
        .led_data  (led_data),
        .led_ack   (led_ack),
        .p2s_start (p2s_start),
        .p2s_pdata (p2s_pdata),
        .p2s_en    (p2s_en),
        .busy      (busy),
        .grant_id  (grant_id),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        start_q <= p2s_start;
        if (p2s_start && !start_q && !shf_dead) begin
            pend <= 1;
        end else if (pend == 1) begin
            pend   <= 0;
            p2s_en <= 1'b0;
            run    <= 64;
        end else if (run > 0) begin
            run <= run - 1;
            if (run == 1) p2s_en <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nvec++;
        assert (obs === expv)
        else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"}, 64'(p2s_start), 64'(0));
        chk({tag, "_pdata"}, p2s_pdata, 64'(0));
        chk({tag, "_acks"}, 64'({seg_ack, led_ack}), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
        chk({tag, "_gid"}, 64'(grant_id), 64'(1));
    endtask

    // Called at the negedge of the grant cycle n (IDLE, EN=1, request present).
    // Expected: start at n+1, ack at n+68 (shifter) or err at n+6 / ack at n+7.
    task automatic run_xfer(input logic exp_id, input bit exp_err, input bit chg, input bit pulse_led);
        logic [63:0] exp_data;
        int start_k, nstart, ack_k, err_k, nerrp, wrong;
        bit held;
        exp_data = exp_id ? led_data : seg_data;
        start_k = -1; nstart = 0; ack_k = -1; err_k = -1; nerrp = 0; wrong = 0; held = 1'b1;
        chk("start_low_at_grant", 64'(p2s_start), 64'(0));
        for (int k = 1; k <= 200 && ack_k < 0; k++) begin
            @(negedge clk);
            if (p2s_start) begin
                nstart++;
                if (start_k < 0) start_k = k;
            end
            if (err) begin
                nerrp++;
                err_k = k;
            end
            if (p2s_pdata !== exp_data) held = 1'b0;
            if (exp_id ? seg_ack : led_ack) wrong++;
            if (exp_id ? led_ack : seg_ack) ack_k = k;
            if (k == 1 && chg) begin
                seg_data = ~seg_data;
                led_data = ~led_data;
            end
            if (pulse_led) led_req = (k == 5);
        end
        chk("start_cycle", 64'(start_k), 64'(1));
        chk("start_count", 64'(nstart), 64'(1));
        chk("pdata_held", 64'(held), 64'(1));
        chk("ack_cycle", 64'(ack_k), exp_err ? 64'(7) : 64'(68));
        chk("other_ack", 64'(wrong), 64'(0));
        chk("err_count", 64'(nerrp), 64'(exp_err));
        if (exp_err) chk("err_cycle", 64'(err_k), 64'(6));
        chk("grant_id", 64'(grant_id), 64'(exp_id));
        last_gnt = exp_id;
        @(negedge clk);
        chk("ack_len", 64'({seg_ack, led_ack}), 64'(0));
        chk("busy_after", 64'(busy), 64'(0));
    endtask

    initial begin
        int cnt;
        logic id;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Tie for three transfers: seg, led, seg
        seg_data = {$urandom, $urandom};
        led_data = {$urandom, $urandom};
        seg_req = 1'b1;
        led_req = 1'b1;
        run_xfer(1'b0, 1'b0, 1'b0, 1'b0);
        run_xfer(1'b1, 1'b0, 1'b0, 1'b0);
        run_xfer(1'b0, 1'b0, 1'b0, 1'b0);
        seg_req = 1'b0;
        led_req = 1'b0;
        @(negedge clk);

        // Single seg request
        seg_data = 64'h0123_4567_89AB_CDEF;
        seg_req = 1'b1;
        run_xfer(1'b0, 1'b0, 1'b0, 1'b0);
        seg_req = 1'b0;

        // LED data changes after grant
        led_data = 64'hAAAA_AAAA_AAAA_AAAA;
        led_req = 1'b1;
        run_xfer(1'b1, 1'b0, 1'b1, 1'b0);
        chk("led_data_flipped", led_data, 64'h5555_5555_5555_5555);
        led_req = 1'b0;

        // Shifter never drops EN: start timeout
        shf_dead = 1'b1;
        seg_req = 1'b1;
        run_xfer(1'b0, 1'b1, 1'b0, 1'b0);
        seg_req = 1'b0;
        shf_dead = 1'b0;
        @(negedge clk);

        // LED request pulsed while seg is busy is lost
        seg_req = 1'b1;
        run_xfer(1'b0, 1'b0, 1'b0, 1'b1);
        seg_req = 1'b0;
        cnt = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (p2s_start || led_ack || busy) cnt++;
        end
        chk("no_led_xfer", 64'(cnt), 64'(0));

        // Reset during WAIT_DONE with EN low
        seg_data = {$urandom, $urandom};
        seg_req = 1'b1;
        repeat (20) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("mid_rst");
        last_gnt = 1'b1;
        cnt = 0;
        for (int k = 0; k < 100 && !p2s_en; k++) begin
            @(negedge clk);
            if (p2s_start || seg_ack || led_ack || busy) cnt++;
        end
        chk("hold_until_en", 64'(cnt), 64'(0));
        chk("en_back", 64'(p2s_en), 64'(1));
        run_xfer(1'b0, 1'b0, 1'b0, 1'b0);
        seg_req = 1'b0;

        // Random requests against a round-robin reference
        for (int i = 0; i < 40; i++) begin
            if (!seg_req) seg_req = 1'($urandom_range(0, 1));
            if (!led_req) led_req = 1'($urandom_range(0, 1));
            seg_data = {$urandom, $urandom};
            led_data = {$urandom, $urandom};
            if (seg_req || led_req) begin
                id = (seg_req && led_req) ? ~last_gnt : led_req;
                run_xfer(id, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
                if (id) led_req = 1'b0;
                else seg_req = 1'b0;
            end else begin
                @(negedge clk);
                chk("idle_quiet", 64'({p2s_start, busy}), 64'(0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
